// File: rtl/i2s_tx_stream_if.sv
// Sample stream interface for i2s_tx_stream.
// Carries one stereo sample pair per valid/ready transfer.
//   in_l / in_r : left/right sample, two's complement, DATA_W bits
//   in_valid    : sample pair valid (source -> transmitter)
//   in_ready    : transmitter holding buffer empty (transmitter -> source)
// Modports: master = audio source, slave = transmitter.
interface i2s_tx_stream_if #(
  parameter int unsigned DATA_W = 16
) ();
  logic [DATA_W-1:0] in_l;
  logic [DATA_W-1:0] in_r;
  logic              in_valid;
  logic              in_ready;

  modport master (output in_l, output in_r, output in_valid, input in_ready);
  modport slave  (input in_l, input in_r, input in_valid, output in_ready);
endinterface

// File: rtl/i2s_tx_stream.sv
// I2S / left-justified audio transmitter.
// A free-running counter generates mclk, sclk and lrclk; one stereo sample pair is serialised
// MSB first per frame. Samples enter a one-deep holding buffer via valid/ready and are moved to
// the active registers at the frame load (counter all-ones).
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   s_in       : sample stream (slave modport: in_l, in_r, in_valid in; in_ready out)
//   mute       : sampled at frame load; a muted frame sends zero samples
//   mclk, sclk : master and bit clocks (counter taps)
//   lrclk      : 0 = left slot, 1 = right slot
//   sdin       : registered serial data, changes with sclk falling edge
//   underrun   : one-cycle pulse after a frame load that found the holding buffer empty
module i2s_tx_stream #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned SLOT_BITS = 16,
  parameter int unsigned MCLK_LOG2 = 2,
  parameter int unsigned SCLK_LOG2 = 4,
  parameter int unsigned LJ_MODE   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  i2s_tx_stream_if.slave        s_in,
  input  logic                  mute,
  output logic                  mclk,
  output logic                  sclk,
  output logic                  lrclk,
  output logic                  sdin,
  output logic                  underrun
);

  localparam int unsigned PW = $clog2(SLOT_BITS);
  localparam int unsigned T  = SCLK_LOG2 + PW + 1;
  localparam logic [DATA_W-1:0] LsbOne = {{(DATA_W-1){1'b0}}, 1'b1};

  logic [T-1:0]      r_cnt;
  logic [DATA_W-1:0] r_hold_l, r_hold_r;
  logic              r_hold_valid;
  logic [DATA_W-1:0] r_act_l, r_act_r;
  logic              r_sdin;
  logic              r_underrun;

  logic [T-1:0]      w_cnt_nxt;
  logic              w_load;
  logic              w_bit_end;
  logic              w_xfer;
  logic [DATA_W-1:0] w_act_l_d, w_act_r_d;
  logic              w_hold_valid_d;
  logic              w_underrun_d;
  logic [PW-1:0]     w_pos;
  logic [31:0]       w_pos32;
  logic              w_rslot;
  logic [DATA_W-1:0] w_word;
  logic [DATA_W-1:0] w_mask;
  logic              w_bit;

  assign w_cnt_nxt = r_cnt + T'(1);
  assign w_load    = &r_cnt;
  assign w_bit_end = &r_cnt[SCLK_LOG2-1:0];

  assign s_in.in_ready = !r_hold_valid;
  assign w_xfer        = s_in.in_valid && !r_hold_valid;

  // Frame load and holding-buffer bookkeeping. A transfer can only happen with the buffer
  // empty, so it never collides with the load emptying it.
  always_comb begin
    w_act_l_d      = r_act_l;
    w_act_r_d      = r_act_r;
    w_hold_valid_d = r_hold_valid;
    w_underrun_d   = 1'b0;
    if (w_load) begin
      if (mute) begin
        w_act_l_d = '0;
        w_act_r_d = '0;
      end else if (r_hold_valid) begin
        w_act_l_d      = r_hold_l;
        w_act_r_d      = r_hold_r;
        w_hold_valid_d = 1'b0;
      end else begin
        w_underrun_d = 1'b1;
      end
    end
    if (w_xfer) begin
      w_hold_valid_d = 1'b1;
    end
  end

  // sdin is computed for the position that starts on the next cycle; the post-load sample
  // values are used so the first bit of a frame already reflects the new sample.
  assign w_pos   = w_cnt_nxt[T-2:SCLK_LOG2];
  assign w_pos32 = 32'(w_pos);
  assign w_rslot = w_cnt_nxt[T-1];
  assign w_word  = w_rslot ? w_act_r_d : w_act_l_d;

  always_comb begin
    w_mask = '0;
    w_bit  = 1'b0;
    if (LJ_MODE != 0) begin
      if (w_pos32 < DATA_W) begin
        w_mask = LsbOne << (DATA_W - 1 - w_pos32);
        w_bit  = |(w_word & w_mask);
      end
    end else begin
      if (w_pos32 == 32'd0) begin
        // I2S delay: slot start carries the previous slot's LSB; at frame start that is the
        // right sample from before the load.
        w_bit = w_rslot ? w_act_l_d[0] : r_act_r[0];
      end else if (w_pos32 <= DATA_W) begin
        w_mask = LsbOne << (DATA_W - w_pos32);
        w_bit  = |(w_word & w_mask);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_hold_l     <= '0;
      r_hold_r     <= '0;
      r_hold_valid <= 1'b0;
      r_act_l      <= '0;
      r_act_r      <= '0;
      r_sdin       <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_cnt        <= w_cnt_nxt;
      r_hold_valid <= w_hold_valid_d;
      r_act_l      <= w_act_l_d;
      r_act_r      <= w_act_r_d;
      r_underrun   <= w_underrun_d;
      if (w_xfer) begin
        r_hold_l <= s_in.in_l;
        r_hold_r <= s_in.in_r;
      end
      if (w_bit_end) begin
        r_sdin <= w_bit;
      end
    end
  end

  assign mclk     = r_cnt[MCLK_LOG2-1];
  assign sclk     = r_cnt[SCLK_LOG2-1];
  assign lrclk    = r_cnt[T-1];
  assign sdin     = r_sdin;
  assign underrun = r_underrun;

endmodule

// File: tb/tb_i2s_tx_stream.sv
// Directed bench for i2s_tx_stream: a default I2S instance and a 24-bit left-justified
// instance sharing clock and reset. The bench counts cycles since reset release, so the
// DUT counter value is known as cyc mod frame length.
module tb_i2s_tx_stream;

  logic clk;
  logic rst_n;
  logic mute1, mclk1, sclk1, lrclk1, sdin1, underrun1;
  logic mute2, mclk2, sclk2, lrclk2, sdin2, underrun2;

  int cyc;
  int n_cmp;
  int n_err;

  i2s_tx_stream_if #(.DATA_W(16)) u_if1 ();
  i2s_tx_stream_if #(.DATA_W(24)) u_if2 ();

  i2s_tx_stream u_dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_in     (u_if1.slave),
    .mute     (mute1),
    .mclk     (mclk1),
    .sclk     (sclk1),
    .lrclk    (lrclk1),
    .sdin     (sdin1),
    .underrun (underrun1)
  );

  i2s_tx_stream #(
    .DATA_W    (24),
    .SLOT_BITS (32),
    .MCLK_LOG2 (2),
    .SCLK_LOG2 (4),
    .LJ_MODE   (1)
  ) u_dut2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_in     (u_if2.slave),
    .mute     (mute2),
    .mclk     (mclk2),
    .sclk     (sclk2),
    .lrclk    (lrclk2),
    .sdin     (sdin2),
    .underrun (underrun2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance to 1 time unit after the clock edge that makes the bench count reach target.
  task automatic step_to(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  // Collect one slot, first bit lands in the MSB; each bit sampled mid-sclk-period.
  task automatic read_word(input int base, input int nbits, input bit sel2,
                           output logic [31:0] w);
    w = '0;
    for (int p = 0; p < nbits; p++) begin
      step_to(base + p * 16 + 8);
      w = {w[30:0], (sel2 ? sdin2 : sdin1)};
    end
  endtask

  task automatic push1(input logic [15:0] l, input logic [15:0] r);
    u_if1.in_l     = l;
    u_if1.in_r     = r;
    u_if1.in_valid = 1'b1;
    check_eq("push1_ready_before", 32'(u_if1.in_ready), 32'd1);
    @(posedge clk);
    #1;
    cyc++;
    u_if1.in_valid = 1'b0;
    check_eq("push1_ready_after", 32'(u_if1.in_ready), 32'd0);
  endtask

  function automatic logic [31:0] clks1();
    return 32'({mclk1, sclk1, lrclk1});
  endfunction

  int          tc_cyc [8] = '{1, 2, 4, 6, 8, 16, 255, 256};
  logic [2:0]  tc_exp [8] = '{3'b000, 3'b100, 3'b000, 3'b100, 3'b010, 3'b000, 3'b110, 3'b001};
  logic [31:0] w;

  initial begin
    n_cmp = 0;
    n_err = 0;
    cyc = 0;
    rst_n = 1'b0;
    mute1 = 1'b0;
    mute2 = 1'b0;
    u_if1.in_l = '0;
    u_if1.in_r = '0;
    u_if1.in_valid = 1'b0;
    u_if2.in_l = '0;
    u_if2.in_r = '0;
    u_if2.in_valid = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_clks", clks1(), 32'd0);
    check_eq("rst_sdin", 32'(sdin1), 32'd0);
    check_eq("rst_underrun", 32'(underrun1), 32'd0);
    check_eq("rst_ready", 32'(u_if1.in_ready), 32'd1);

    // Clock generation: mclk = cnt[1], sclk = cnt[3], lrclk = cnt[8].
    rst_n = 1'b1;
    cyc = 0;
    for (int i = 0; i < 8; i++) begin
      step_to(tc_cyc[i]);
      check_eq("clk_gen", clks1(), 32'(tc_exp[i]));
    end

    push1(16'hA5C3, 16'h0F01);
    step_to(511);
    check_eq("clk_gen_511", clks1(), 32'b111);
    step_to(512);
    check_eq("clk_gen_512", clks1(), 32'b000);
    check_eq("underrun_f1", 32'(underrun1), 32'd0);
    step_to(513);
    check_eq("ready_after_load", 32'(u_if1.in_ready), 32'd1);

    // Frame 1: left p0 = old right LSB (0), then A5C3[15:1]; right p0 = A5C3[0].
    read_word(512, 16, 1'b0, w);
    check_eq("f1_left", w, 32'h52E1);
    read_word(768, 16, 1'b0, w);
    check_eq("f1_right", w, 32'h8780);

    // No new sample: underrun pulse, same sample repeats with p0 = 0F01[0].
    step_to(1024);
    check_eq("underrun_f2", 32'(underrun1), 32'd1);
    step_to(1025);
    check_eq("underrun_f2_end", 32'(underrun1), 32'd0);
    read_word(1024, 16, 1'b0, w);
    check_eq("f2_left", w, 32'hD2E1);
    read_word(1280, 16, 1'b0, w);
    check_eq("f2_right", w, 32'h8780);
    step_to(1536);
    check_eq("underrun_f3", 32'(underrun1), 32'd1);

    // Mute at the load with a sample held.
    step_to(1600);
    push1(16'h1234, 16'h8001);
    mute1 = 1'b1;
    step_to(2048);
    check_eq("underrun_muted", 32'(underrun1), 32'd0);
    step_to(2050);
    mute1 = 1'b0;
    step_to(2100);
    check_eq("ready_muted", 32'(u_if1.in_ready), 32'd0);
    // p0 of the left slot still carries the pre-load right LSB; the sample bits are zero.
    read_word(2048, 16, 1'b0, w);
    check_eq("f4_left_muted", w & 32'h7FFF, 32'h0);
    read_word(2304, 16, 1'b0, w);
    check_eq("f4_right_muted", w, 32'h0);
    step_to(2560);
    check_eq("underrun_f5", 32'(underrun1), 32'd0);
    step_to(2561);
    check_eq("ready_f5", 32'(u_if1.in_ready), 32'd1);
    read_word(2560, 16, 1'b0, w);
    check_eq("f5_left", w, 32'h091A);
    read_word(2816, 16, 1'b0, w);
    check_eq("f5_right", w, 32'h4000);

    // Reset mid right slot with the holding buffer full.
    step_to(3080);
    push1(16'hFFFF, 16'hFFFF);
    step_to(3072 + 256 + 5 * 16 + 10);
    check_eq("pre_rst_clks", clks1(), 32'b111);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_clks", clks1(), 32'd0);
    check_eq("mid_rst_sdin", 32'(sdin1), 32'd0);
    check_eq("mid_rst_underrun", 32'(underrun1), 32'd0);
    check_eq("mid_rst_ready", 32'(u_if1.in_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;

    // Left-justified 24-bit instance, loaded during frame 0 (1024 clk frames).
    step_to(10);
    u_if2.in_l = 24'h800001;
    u_if2.in_r = 24'hC00000;
    u_if2.in_valid = 1'b1;
    check_eq("push2_ready_before", 32'(u_if2.in_ready), 32'd1);
    step_to(11);
    u_if2.in_valid = 1'b0;
    check_eq("push2_ready_after", 32'(u_if2.in_ready), 32'd0);

    // Held sample was discarded by the reset: underrun at first load, silent frame.
    step_to(512);
    check_eq("underrun_after_rst", 32'(underrun1), 32'd1);
    read_word(512, 16, 1'b0, w);
    check_eq("post_rst_left", w, 32'h0);

    read_word(1024, 32, 1'b1, w);
    check_eq("lj_left", w, 32'h80000100);
    read_word(1536, 32, 1'b1, w);
    check_eq("lj_right", w, 32'hC0000000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
